// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: clock inhibit, request-to-send, 11-bit frame shift-out
// on device clock falls, then ACK sampling and bus-idle wait. Outputs are open-drain enables.
module ps2_host_tx #(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter int unsigned INHIBIT_US     = 100,
    parameter int unsigned TIMEOUT_CYCLES = 750_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clock_in,
    input  logic       ps2_data_in,
    output logic       ps2_clock_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned INHIBIT_CYCLES = CLK_HZ / 1_000_000 * INHIBIT_US;
    localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                       : TIMEOUT_CYCLES;
    localparam int unsigned CntW = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
    localparam logic [CntW-1:0] DataLead    = CntW'(INHIBIT_CYCLES - 2);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne      = CntW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StInhibit,
        StRelease,
        StWaitIdle
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              nack_q, nack_d;
    logic              clk_oe_q, clk_oe_d;
    logic              data_oe_q, data_oe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [2:0]        clk_sync_q, clk_sync_d;
    logic [1:0]        data_sync_q, data_sync_d;

    logic clk_s;
    logic data_s;
    logic fall;

    // Stage [1] is the synchronized level; stage [2] is its previous value for edge detection.
    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];
    assign fall   = clk_sync_q[2] & ~clk_sync_q[1];

    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], ps2_clock_in};
        data_sync_d = {data_sync_q[0], ps2_data_in};

        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        nack_d    = nack_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                if (tx_start) begin
                    shift_d  = tx_data;
                    parity_d = ~^tx_data;
                    nack_d   = 1'b0;
                    cnt_d    = '0;
                    bit_d    = '0;
                    clk_oe_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = StInhibit;
                end
            end

            StInhibit: begin
                cnt_d = cnt_q + CntOne;
                // Start bit goes out during the last inhibit cycle.
                if (cnt_q == DataLead) begin
                    data_oe_d = 1'b1;
                end
                if (cnt_q == InhibitLast) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = StRelease;
                end
            end

            StRelease: begin
                if (fall) begin
                    cnt_d = '0;
                    bit_d = bit_q + 4'd1;
                    if (bit_q < 4'd8) begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end else if (bit_q == 4'd8) begin
                        data_oe_d = ~parity_q;
                    end else if (bit_q == 4'd9) begin
                        data_oe_d = 1'b0;
                    end else begin
                        nack_d  = data_s;
                        state_d = StWaitIdle;
                    end
                end else if (cnt_q == TimeoutLast) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    error_d   = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StWaitIdle: begin
                if (clk_s && data_s) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    error_d   = nack_q;
                    state_d   = StIdle;
                end else if (cnt_q == TimeoutLast) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    error_d   = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            nack_q      <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            // Idle bus level, so leaving reset never looks like a clock fall.
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            nack_q      <= nack_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
        end
    end

    assign ps2_clock_oe = clk_oe_q;
    assign ps2_data_oe  = data_oe_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and compares them
// with frames built from the byte by a parity-counting reference model.
module tb_ps2_host_tx;

    localparam int unsigned ClkHz         = 1_000_000;
    localparam int unsigned InhibitUs     = 100;
    localparam int unsigned TimeoutCycles = 2000;
    localparam int unsigned InhibitCycles = 100;
    localparam int          HalfPeriod    = 20;

    typedef struct packed {
        logic [7:0] data;
        logic       nack;
        logic       exp_parity;
        logic       exp_error;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       dev_clk;
    logic       dev_data;
    logic       ps2_clock_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       error;
    logic       pin_clk;
    logic       pin_data;

    // Open-drain wired-AND of host and device.
    assign pin_clk  = dev_clk & ~ps2_clock_oe;
    assign pin_data = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .CLK_HZ        (ClkHz),
        .INHIBIT_US    (InhibitUs),
        .TIMEOUT_CYCLES(TimeoutCycles)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .ps2_clock_in(pin_clk),
        .ps2_data_in (pin_data),
        .ps2_clock_oe(ps2_clock_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clock = ~clock;

    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    int   err_alone = 0;
    int   coe_len = 0;
    int   last_inhibit = 0;
    logic last_err = 1'b0;
    logic lead_ok = 1'b0;
    logic prev_coe = 1'b0;
    logic d1 = 1'b0;
    logic d2 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle observation of done/error pulses and inhibit window length.
    task automatic sample();
        if (done) begin
            done_cnt++;
            last_err = error;
        end
        if (error && !done) err_alone++;
        if (ps2_clock_oe) begin
            coe_len++;
        end else if (prev_coe) begin
            last_inhibit = coe_len;
            coe_len      = 0;
            lead_ok      = d1 && !d2;
        end
        d2       = d1;
        d1       = ps2_data_oe;
        prev_coe = ps2_clock_oe;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            sample();
        end
    endtask

    function automatic logic [10:0] model_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d, 1'b0};
    endfunction

    task automatic start(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        tx_data  = 8'($urandom());
    endtask

    task automatic wait_rts(output bit ok);
        int t = 0;
        while (!(pin_clk && !pin_data) && t < 1000) begin
            tick(1);
            t++;
        end
        ok = pin_clk && !pin_data;
    endtask

    task automatic dev_xfer(input logic nack, output logic [10:0] frame, output bit ok);
        frame = '1;
        wait_rts(ok);
        if (ok) begin
            tick(10);
            frame[0] = pin_data;
            for (int k = 1; k <= 10; k++) begin
                dev_clk = 1'b0;
                tick(HalfPeriod);
                dev_clk = 1'b1;
                tick(HalfPeriod / 2);
                frame[k] = pin_data;
                if (k == 10) dev_data = nack;
                tick(HalfPeriod / 2);
            end
            dev_clk = 1'b0;
            tick(HalfPeriod);
            dev_clk = 1'b1;
            tick(5);
            dev_data = 1'b1;
        end
    endtask

    task automatic wait_done(input int base);
        for (int t = 0; t < 300 && done_cnt == base; t++) tick(1);
        check("done_pulse_count", done_cnt - base, 1);
    endtask

    task automatic transfer(input logic [7:0] d, input logic nack, output logic [10:0] frame);
        int   base;
        bit   ok;
        base = done_cnt;
        start(d);
        check("busy_on_accept", busy, 1);
        check("clk_oe_on_accept", ps2_clock_oe, 1);
        dev_xfer(nack, frame, ok);
        check("rts_seen", ok, 1);
        check("frame", frame, model_frame(d));
        check("inhibit_len", last_inhibit, InhibitCycles);
        check("start_bit_lead", lead_ok, 1);
        wait_done(base);
        check("error_flag", last_err, nack);
        check("busy_after_done", busy, 0);
        check("lines_released", {ps2_clock_oe, ps2_data_oe}, 0);
    endtask

    initial begin
        vec_t        vecs[4];
        logic [10:0] frame;
        logic [7:0]  rd;
        logic        rn;
        bit          ok;
        int          base;
        int          t;

        vecs[0] = '{data: 8'hED, nack: 1'b0, exp_parity: 1'b1, exp_error: 1'b0};
        vecs[1] = '{data: 8'h01, nack: 1'b0, exp_parity: 1'b0, exp_error: 1'b0};
        vecs[2] = '{data: 8'hFF, nack: 1'b0, exp_parity: 1'b1, exp_error: 1'b0};
        vecs[3] = '{data: 8'hED, nack: 1'b1, exp_parity: 1'b1, exp_error: 1'b1};

        reset    = 1'b0;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        tick(3);
        check("rst_clock_oe", ps2_clock_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        reset = 1'b1;
        tick(2);

        // Device clock activity while idle must not start anything.
        dev_clk = 1'b0;
        tick(5);
        dev_clk = 1'b1;
        tick(5);
        check("idle_fall_busy", busy, 0);
        check("idle_fall_oe", {ps2_clock_oe, ps2_data_oe}, 0);
        check("idle_fall_done", done_cnt, 0);

        for (int i = 0; i < 4; i++) begin
            transfer(vecs[i].data, vecs[i].nack, frame);
            check("table_parity_bit", frame[9], vecs[i].exp_parity);
            check("table_error", last_err, vecs[i].exp_error);
        end

        for (int i = 0; i < 6; i++) begin
            rd = 8'($urandom());
            rn = 1'($urandom_range(0, 1));
            transfer(rd, rn, frame);
        end

        // Timeout: device never clocks after release.
        start(8'h3C);
        wait_rts(ok);
        check("timeout_rts_seen", ok, 1);
        t = 0;
        while (!done && t < 2500) begin
            tick(1);
            t++;
        end
        checks++;
        if (t < int'(TimeoutCycles) || t > int'(TimeoutCycles) + 3) begin
            errors++;
            $display("FAIL timeout_gap: got %0d cycles, want %0d..%0d", t, TimeoutCycles,
                     TimeoutCycles + 3);
        end
        check("timeout_error", error, 1);
        check("timeout_lines", {ps2_clock_oe, ps2_data_oe}, 0);
        check("timeout_busy", busy, 0);
        tick(2);

        // Reset while bit 4 (a zero) is being driven.
        start(8'hA5);
        wait_rts(ok);
        tick(10);
        for (int k = 1; k <= 5; k++) begin
            dev_clk = 1'b0;
            tick(HalfPeriod);
            if (k < 5) begin
                dev_clk = 1'b1;
                tick(HalfPeriod);
            end
        end
        check("bit4_driven_low", ps2_data_oe, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_clock_oe", ps2_clock_oe, 0);
        check("async_rst_data_oe", ps2_data_oe, 0);
        check("async_rst_busy", busy, 0);
        dev_clk = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(2);
        transfer(8'hF4, 1'b0, frame);

        // Start while busy is dropped; start during the done cycle is taken.
        base = done_cnt;
        start(8'h33);
        tick(20);
        tx_data  = 8'hAA;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        check("ignored_start_busy", busy, 1);
        dev_xfer(1'b0, frame, ok);
        check("b2b_first_frame", frame, model_frame(8'h33));
        check("b2b_first_inhibit", last_inhibit, InhibitCycles);
        t = 0;
        while (!done && t < 300) begin
            tick(1);
            t++;
        end
        check("b2b_done_seen", done, 1);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        tx_data  = 8'($urandom());
        check("b2b_accept_busy", busy, 1);
        check("b2b_accept_clk_oe", ps2_clock_oe, 1);
        dev_xfer(1'b0, frame, ok);
        check("b2b_second_frame", frame, model_frame(8'h55));
        wait_done(base + 1);
        check("b2b_second_error", last_err, 0);

        check("error_without_done", err_alone, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
